// File: rtl/cacheline_bmem_adapter.sv
// ---------------------------------------------------------------------------
// cacheline_bmem_adapter
//
// Purpose:
//   Initiator side of the burst memory interface. A single 256-bit cache-line
//   read or write request from the last-level cache becomes one 4-beat,
//   64-bit burst on the burst memory bus, followed by a single one-cycle
//   completion pulse back to the cache.
//
// Ports:
//   clk, rst_n   - single clock, asynchronous active-low reset
//   dfp_addr     - line byte address from the cache (offset bits ignored)
//   dfp_read     - line read request, level, held until dfp_resp
//   dfp_write    - line write request, level, held until dfp_resp
//   dfp_wdata    - line to be written
//   dfp_rdata    - assembled read line, valid while dfp_resp is high
//   dfp_resp     - one-cycle completion pulse
//   bmem_addr    - line-aligned burst base address
//   bmem_read    - burst read request
//   bmem_write   - burst write request
//   bmem_wdata   - current write beat
//   bmem_rdata   - read beat from memory
//   bmem_resp    - beat valid (read) / beat strobe (write)
// ---------------------------------------------------------------------------
module cacheline_bmem_adapter #(
  parameter  int BUS_WIDTH  = 64,
  parameter  int BURST_LEN  = 4,
  localparam int LINE_WIDTH = BUS_WIDTH * BURST_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic [31:0]           dfp_addr,
  input  logic                  dfp_read,
  input  logic                  dfp_write,
  input  logic [LINE_WIDTH-1:0] dfp_wdata,
  output logic [LINE_WIDTH-1:0] dfp_rdata,
  output logic                  dfp_resp,

  output logic [31:0]           bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [BUS_WIDTH-1:0]  bmem_wdata,
  input  logic [BUS_WIDTH-1:0]  bmem_rdata,
  input  logic                  bmem_resp
);

  localparam int CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int BSEL_W = $clog2(BUS_WIDTH);
  localparam int OFF_W  = $clog2(LINE_WIDTH / 8);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RD_BURST = 2'd1;
  localparam logic [1:0] WR_BURST = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  logic [1:0]            state_q,    state_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [31:0]           addr_q,     addr_d;
  logic [LINE_WIDTH-1:0] line_q,     line_d;

  // Bit offset of the current beat inside the line; beats are ascending with
  // no wrap, so this is just the beat counter scaled by the bus width.
  logic [CNT_W+BSEL_W-1:0] beat_lsb;
  assign beat_lsb = {beat_cnt_q, {BSEL_W{1'b0}}};

  // The byte offset within the line never reaches the bus: bursts always
  // start at the line base.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, dfp_addr[OFF_W-1:0]};

  // Next-state logic. One line buffer serves both directions: it holds the
  // latched write line during a write burst and collects beats during a read.
  // The cache inputs are only looked at in IDLE, so changes mid-burst are
  // harmless.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    addr_d     = addr_q;
    line_d     = line_q;
    case (state_q)
      IDLE: begin
        if (dfp_write) begin
          addr_d     = {dfp_addr[31:OFF_W], {OFF_W{1'b0}}};
          line_d     = dfp_wdata;
          beat_cnt_d = '0;
          state_d    = WR_BURST;
        end else if (dfp_read) begin
          addr_d     = {dfp_addr[31:OFF_W], {OFF_W{1'b0}}};
          beat_cnt_d = '0;
          state_d    = RD_BURST;
        end
      end
      RD_BURST: begin
        if (bmem_resp) begin
          line_d[beat_lsb +: BUS_WIDTH] = bmem_rdata;
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      WR_BURST: begin
        if (bmem_resp) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; an asynchronous reset abandons any burst in flight and
  // clears the line buffer so every output reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      addr_q     <= '0;
      line_q     <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      addr_q     <= addr_d;
      line_q     <= line_d;
    end
  end

  // Bus-side outputs are decoded from registers only, so address and
  // request lines are glitch-free and held for the whole burst.
  assign bmem_addr  = addr_q;
  assign bmem_read  = (state_q == RD_BURST);
  assign bmem_write = (state_q == WR_BURST);
  assign bmem_wdata = (state_q == WR_BURST) ? line_q[beat_lsb +: BUS_WIDTH] : '0;

  assign dfp_resp   = (state_q == DONE);
  assign dfp_rdata  = line_q;

endmodule

// File: tb/tb_cacheline_bmem_adapter.sv
// ---------------------------------------------------------------------------
// tb_cacheline_bmem_adapter
//
// Purpose:
//   Drives cache-side line requests into cacheline_bmem_adapter, plays the
//   burst memory on the bus side, and compares every burst beat and every
//   completion against a line-level reference model through a queue of
//   expected transactions.
// ---------------------------------------------------------------------------
module tb_cacheline_bmem_adapter;

  localparam int BW = 64;
  localparam int BL = 4;
  localparam int LW = BW * BL;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   dfp_addr;
  logic          dfp_read;
  logic          dfp_write;
  logic [LW-1:0] dfp_wdata;
  logic [LW-1:0] dfp_rdata;
  logic          dfp_resp;
  logic [31:0]   bmem_addr;
  logic          bmem_read;
  logic          bmem_write;
  logic [BW-1:0] bmem_wdata;
  logic [BW-1:0] bmem_rdata;
  logic          bmem_resp;

  cacheline_bmem_adapter #(.BUS_WIDTH(BW), .BURST_LEN(BL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dfp_addr   (dfp_addr),
    .dfp_read   (dfp_read),
    .dfp_write  (dfp_write),
    .dfp_wdata  (dfp_wdata),
    .dfp_rdata  (dfp_rdata),
    .dfp_resp   (dfp_resp),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata),
    .bmem_rdata (bmem_rdata),
    .bmem_resp  (bmem_resp)
  );

  // Free-running clock
  always #5 clk = ~clk;

  typedef struct {
    logic          is_write;
    logic [31:0]   base;
    logic [LW-1:0] line;
  } exp_t;

  exp_t          exp_q[$];
  logic [LW-1:0] model_line [32];
  logic [BW-1:0] mem        [128];

  int pass_cnt      = 0;
  int check_cnt     = 0;
  int resp_seen     = 0;
  int resp_expected = 0;
  int resp_beats    = 0;
  int gap_left      = 0;
  bit in_burst      = 1'b0;
  bit end_pending   = 1'b0;
  bit stall_mode    = 1'b0;
  bit prev_resp     = 1'b0;

  task automatic checkOutput(input string name, input logic [LW-1:0] act,
                             input logic [LW-1:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [LW-1:0] randLine();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Burst memory responder: answers beats with random gaps (or a fixed
  // 3-cycle gap between beats 1 and 2 in stall mode), toggles bmem_resp
  // randomly while no burst is active, and checks address/direction
  // stability, write beat order and the exact burst end timing.
  initial begin : responder
    exp_t       e;
    logic [6:0] idx;
    bmem_resp  = 1'b0;
    bmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_burst    = 1'b0;
        end_pending = 1'b0;
        resp_beats  = 0;
        bmem_resp   = 1'b0;
        continue;
      end
      if (end_pending) begin
        checkOutput("burst_end", LW'({dfp_resp, bmem_read, bmem_write}), LW'(3'b100));
        end_pending = 1'b0;
        in_burst    = 1'b0;
      end else if (!in_burst && (bmem_read || bmem_write)) begin
        in_burst   = 1'b1;
        resp_beats = 0;
        gap_left   = stall_mode ? 0 : int'($urandom_range(0, 2));
      end
      if (in_burst && !end_pending) begin
        checkOutput("burst_has_exp", LW'(exp_q.size()), LW'(1));
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          checkOutput("bmem_addr", LW'(bmem_addr), LW'(e.base));
          checkOutput("bmem_rw", LW'({bmem_read, bmem_write}),
                      LW'(e.is_write ? 2'b01 : 2'b10));
          if (gap_left > 0) begin
            gap_left--;
            bmem_resp = 1'b0;
          end else begin
            bmem_resp = 1'b1;
            idx = bmem_addr[9:3] + 7'(resp_beats);
            if (e.is_write) begin
              checkOutput("bmem_wdata", LW'(bmem_wdata), LW'(e.line[resp_beats*BW +: BW]));
              mem[idx] = bmem_wdata;
            end else begin
              bmem_rdata = mem[idx];
            end
            resp_beats++;
            if (resp_beats == BL) end_pending = 1'b1;
            else gap_left = stall_mode ? ((resp_beats == 2) ? 3 : 0)
                                       : int'($urandom_range(0, 2));
          end
        end
      end else if (!in_burst) begin
        bmem_resp  = 1'($urandom_range(0, 1));
        bmem_rdata = {$urandom, $urandom};
      end
    end
  end

  // Completion monitor: every dfp_resp pops one expected transaction, must
  // be a single-cycle pulse, and for reads must carry the model's line.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (dfp_resp) begin
          resp_seen++;
          checkOutput("resp_pulse", LW'(prev_resp), LW'(0));
          checkOutput("resp_has_exp", LW'(exp_q.size()), LW'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (!e.is_write) checkOutput("dfp_rdata", dfp_rdata, e.line);
          end
        end
        prev_resp = dfp_resp;
      end else begin
        prev_resp = 1'b0;
      end
    end
  end

  // Cache-side request: kind 0 = read, 1 = write, 2 = read and write together
  task automatic issue(input int kind, input logic [31:0] addr, input logic [LW-1:0] wdata);
    exp_t e;
    e.is_write = (kind != 0);
    e.base     = {addr[31:5], 5'b0};
    e.line     = e.is_write ? wdata : model_line[addr[9:5]];
    if (e.is_write) model_line[addr[9:5]] = wdata;
    exp_q.push_back(e);
    resp_expected++;
    dfp_addr  = addr;
    dfp_wdata = wdata;
    dfp_read  = (kind != 1);
    dfp_write = (kind != 0);
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    dfp_read  = 1'b0;
    dfp_write = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Hold the request until dfp_resp, scrambling address/data meanwhile to
  // show they are not re-sampled mid-burst.
  task automatic waitResp();
    int n = 0;
    forever begin
      @(negedge clk);
      if (dfp_resp) break;
      dfp_addr  = $urandom;
      dfp_wdata = randLine();
      n++;
      if (n > 200) begin
        checkOutput("resp_timeout", LW'(n), LW'(0));
        resp_expected--;
        doReset();
        break;
      end
    end
    dfp_read  = 1'b0;
    dfp_write = 1'b0;
  endtask

  task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [LW-1:0] wdata);
    issue(kind, addr, wdata);
    waitResp();
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [LW-1:0] dline;
    int            n;

    dfp_addr  = '0;
    dfp_read  = 1'b0;
    dfp_write = 1'b0;
    dfp_wdata = '0;

    for (int i = 0; i < 128; i++) mem[i] = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) mem[(32'h100 >> 3) + i] = 64'hA0A0_0000_0000_0000 | 64'(i);
    for (int j = 0; j < 32; j++)
      model_line[j] = {mem[4*j+3], mem[4*j+2], mem[4*j+1], mem[4*j]};

    // Reset values
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_flags", LW'({dfp_resp, bmem_read, bmem_write}), LW'(0));
    checkOutput("rst_rdata", dfp_rdata, LW'(0));
    checkOutput("rst_addr", LW'(bmem_addr), LW'(0));
    checkOutput("rst_wdata", LW'(bmem_wdata), LW'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Read fill of the preloaded line at 0x100
    applyStimulus(0, 32'h0000_0100, '0);

    // Line write then readback
    dline = randLine();
    applyStimulus(1, 32'h0000_0240, dline);
    applyStimulus(0, 32'h0000_0240, '0);

    // Unaligned address inside the same line
    applyStimulus(0, 32'h0000_025C, '0);

    // Simultaneous read and write: write wins
    applyStimulus(2, 32'h0000_0080, randLine());
    applyStimulus(0, 32'h0000_0080, '0);

    // Reset after the second read beat has been captured
    issue(0, 32'h0000_0100, '0);
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (resp_beats == 2) break;
      n++;
      if (n > 200) begin
        checkOutput("midrst_timeout", LW'(n), LW'(0));
        break;
      end
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_flags", LW'({dfp_resp, bmem_read, bmem_write}), LW'(0));
    checkOutput("midrst_rdata", dfp_rdata, LW'(0));
    checkOutput("midrst_addr", LW'(bmem_addr), LW'(0));
    checkOutput("midrst_wdata", LW'(bmem_wdata), LW'(0));
    exp_q.delete();
    resp_expected--;
    dfp_read = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(0, 32'h0000_0100, '0);

    // Stall between beats 1 and 2
    stall_mode = 1'b1;
    applyStimulus(0, 32'h0000_0100, '0);
    applyStimulus(1, 32'h0000_0300, randLine());
    applyStimulus(0, 32'h0000_0300, '0);
    stall_mode = 1'b0;

    // Randomized traffic
    for (int t = 0; t < 40; t++)
      applyStimulus(int'($urandom_range(0, 2)), $urandom & 32'h0000_03FF, randLine());

    repeat (4) @(negedge clk);
    checkOutput("queue_empty", LW'(exp_q.size()), LW'(0));
    checkOutput("resp_count", LW'(resp_seen), LW'(resp_expected));

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/cacheline_bmem_adapter.md
# cacheline_bmem_adapter

Synthesizable initiator for the burst memory interface. It converts one 256-bit cache-line read or write request from the last-level cache into a single 4-beat, 64-bit burst on the burst memory bus, then returns one response to the cache. It sits between the cache's downstream port and the burst memory, and is the driving end of the protocol that the burst memory model answers.

## Interface
Parameters:
- BUS_WIDTH, 64, burst memory data width in bits.
- BURST_LEN, 4, beats per burst.
- LINE_WIDTH, BUS_WIDTH*BURST_LEN (256), cache line width in bits; it is derived and must not be overridden.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  the single clock.
- rst_n  in  1  asynchronous, active-low reset.
- dfp_addr  in  32  line byte address; bits [4:0] are ignored.
- dfp_read  in  1  line read request; level, held until dfp_resp.
- dfp_write  in  1  line write request; level, held until dfp_resp.
- dfp_wdata  in  LINE_WIDTH  write line.
- dfp_rdata  out  LINE_WIDTH  read line; valid while dfp_resp=1.
- dfp_resp  out  1  one-cycle completion pulse.
- bmem_addr  out  32  burst base address, equal to {dfp_addr[31:5],5'b0}.
- bmem_read  out  1  burst read request.
- bmem_write  out  1  burst write request.
- bmem_wdata  out  BUS_WIDTH  current write beat.
- bmem_rdata  in  BUS_WIDTH  read beat.
- bmem_resp  in  1  beat valid (read) or beat strobe (write).

## Operation
- The FSM has four states: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - If dfp_write=1, latch the address and dfp_wdata, clear beat_cnt, and go to WR_BURST.
  - Else if dfp_read=1, latch the address, clear beat_cnt, and go to RD_BURST.
  - Write has priority when both requests are asserted.
  - bmem_resp is ignored in IDLE and in DONE.
- RD_BURST:
  - bmem_read=1 and bmem_addr holds the latched value.
  - On each edge with bmem_resp=1, store bmem_rdata into line[BUS_WIDTH*beat_cnt +: BUS_WIDTH] and increment beat_cnt.
  - On the edge that stores beat BURST_LEN-1, go to DONE.
- WR_BURST:
  - bmem_write=1 and bmem_wdata = latched_line[BUS_WIDTH*beat_cnt +: BUS_WIDTH]. Beat 0 is driven from the first cycle.
  - On each edge with bmem_resp=1, increment beat_cnt.
  - On the edge that counts beat BURST_LEN-1, go to DONE.
- DONE: dfp_resp=1 for exactly one cycle. dfp_rdata holds the assembled line for a read and is don't-care for a write. The next state is always IDLE.
- Beat ordering: beat i maps to line bits [64i+63:64i] at address base+8i, in ascending order. There is no wrap.
- Stability: bmem_addr, bmem_read/bmem_write and the beat-select logic are driven only from registers. The address is held constant for the whole burst, and read and write are never asserted together.
- beat_cnt is $clog2(BURST_LEN) bits wide and is compared against BURST_LEN-1 without wrapping.
- The cache's dfp_* inputs are not sampled outside IDLE. Changing them mid-burst has no effect.

## Timing
- Reset (asynchronous, on rst_n=0): state=IDLE, beat_cnt=0, and every output is 0 (dfp_resp, dfp_rdata, bmem_read, bmem_write, bmem_addr, bmem_wdata).
- Deassertion of rst_n is synchronized by the flop.
- Reset mid-burst abandons the burst immediately. The memory side must be reset alongside it.
- Request acceptance: the request is sampled at edge T0 in IDLE. bmem_read or bmem_write is high from T0 onward.
- Read completion:
  - The memory returns beats on consecutive edges Tk..Tk+3.
  - bmem_read falls after Tk+3, on the same edge that captures the last beat; it must not remain high into Tk+4.
  - dfp_resp is high in the cycle between Tk+3 and Tk+4.
- Write completion:
  - The memory raises bmem_resp and samples bmem_wdata on the 4 edges where bmem_resp=1 is seen.
  - bmem_wdata advances after each of those edges.
  - bmem_write falls after the 4th such edge. dfp_resp is high in the following cycle.
- Adapter overhead: 1 cycle at entry (IDLE to burst) and 1 cycle at exit (DONE), plus the memory latency.
- Back-to-back requests: the earliest next acceptance is the edge after DONE. The cache must sample dfp_resp and drop its request on that same edge.
- Gaps in bmem_resp within a burst are tolerated; the counter only advances on bmem_resp=1.

## Test plan
- Read fill: preload 0x100..0x118 with beats A0..A3 and read at 0x0000_0100. Required: bmem_read held stable for the whole burst, a single dfp_resp, dfp_rdata={A3,A2,A1,A0}, and no memory error flag.
- Line write then readback: write line {D3,D2,D1,D0} at 0x0000_0240, then read 0x0000_0240. Required: bmem_wdata sequence D0,D1,D2,D3; the read returns the identical line.
- Unaligned address: request at 0x0000_025C. Required: bmem_addr=0x0000_0240 for the whole burst.
- Simultaneous read and write in IDLE with address 0x80. Required: a write burst only, bmem_read stays 0, and exactly one dfp_resp.
- Reset mid-burst: drop rst_n after the 2nd read beat. Required: all outputs are 0 immediately with no dfp_resp. After re-reset of both sides, a new read of 0x100 returns {A3,A2,A1,A0}.
- Stall tolerance: the bench responder inserts a 3-cycle gap between beats 1 and 2. Required: the line is assembled correctly and dfp_resp fires once, after beat 3.
